// File: rtl/gray_pkg.sv
// Shared mode encodings and width-generic Gray/binary helpers.
// Helpers work on a 16-bit container; bits at or above w are treated as absent.
package gray_pkg;

  localparam int GW_MAX = 16;

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_UP  = 2'b10;
  localparam logic [1:0] MODE_DN  = 2'b11;

  function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b, input int w);
    logic [GW_MAX-1:0] g;
    g = '0;
    for (int i = 0; i < GW_MAX - 1; i++) begin
      if (i < w - 1) begin
        g[i] = b[i] ^ b[i+1];
      end else if (i == w - 1) begin
        g[i] = b[i];
      end else begin
        g[i] = 1'b0;
      end
    end
    if (w == GW_MAX) begin
      g[GW_MAX-1] = b[GW_MAX-1];
    end else begin
      g[GW_MAX-1] = 1'b0;
    end
    return g;
  endfunction

  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g, input int w);
    logic [GW_MAX-1:0] b;
    logic              acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GW_MAX - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end else begin
        b[i] = 1'b0;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational converter: binary->Gray or Gray->binary, plus a range flag
// on the binary-side value compared at WIDTH+1 bits against MAX.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             g2b_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX);

  logic [GW_MAX-1:0] ext_s;
  logic [WIDTH-1:0]  bin_s;

  // Select direction; the range check always looks at the binary-side value.
  always_comb begin
    ext_s = '0;
    ext_s[WIDTH-1:0] = data_i;
    if (g2b_i) begin
      bin_s  = WIDTH'(gray2bin(ext_s, WIDTH));
      data_o = bin_s;
    end else begin
      bin_s  = data_i;
      data_o = WIDTH'(bin2gray(ext_s, WIDTH));
    end
    err_o = ({1'b0, bin_s} > MAX_W);
  end

endmodule

// File: rtl/gray_codec_counter.sv
// Registered Gray codec / modulo-(MAX+1) up-down counter behind a
// valid/ready handshake with a single output register stage.
module gray_codec_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_wrap
);

  generate
    if (WIDTH < 2 || WIDTH > GW_MAX || MAX < 0 || MAX >= (2 ** WIDTH)) begin : g_bad_params
      $error("gray_codec_counter: need 2<=WIDTH<=16 and 0<=MAX<2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_B  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_B  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_B = WIDTH'(0);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic             out_wrap_q, out_wrap_d;
  logic             accept_s;
  logic [WIDTH-1:0] next_s;
  logic             wrap_s;
  logic [WIDTH-1:0] op_data_s, nx_gray_s;
  logic             op_err_s, nx_err_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_wrap  = out_wrap_q;

  // Operand path; in count modes this is gray(in_data) plus the load range check.
  gray_conv #(.WIDTH(WIDTH), .MAX(MAX)) u_op_conv (
    .data_i (in_data),
    .g2b_i  (mode == MODE_G2B),
    .data_o (op_data_s),
    .err_o  (op_err_s)
  );

  gray_conv #(.WIDTH(WIDTH), .MAX(MAX)) u_nx_conv (
    .data_i (next_s),
    .g2b_i  (1'b0),
    .data_o (nx_gray_s),
    .err_o  (nx_err_s)
  );

  // Modulo step of the counter in the selected direction.
  always_comb begin
    if (mode == MODE_DN) begin
      wrap_s = (cnt_q == ZERO_B);
      next_s = wrap_s ? MAX_B : (cnt_q - ONE_B);
    end else begin
      wrap_s = (cnt_q == MAX_B);
      next_s = wrap_s ? ZERO_B : (cnt_q + ONE_B);
    end
  end

  // Next output register contents and counter value for an accepted beat.
  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_wrap_d  = out_wrap_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept_s) begin
      out_valid_d = 1'b1;
      case (mode)
        MODE_B2G, MODE_G2B: begin
          out_data_d = op_err_s ? ZERO_B : op_data_s;
          out_err_d  = op_err_s;
          out_wrap_d = 1'b0;
        end
        MODE_UP, MODE_DN: begin
          if (load) begin
            out_data_d = op_err_s ? ZERO_B : op_data_s;
            out_err_d  = op_err_s;
            out_wrap_d = 1'b0;
            cnt_d      = op_err_s ? cnt_q : in_data;
          end else begin
            out_data_d = nx_gray_s;
            out_err_d  = nx_err_s;
            out_wrap_d = wrap_s;
            cnt_d      = next_s;
          end
        end
        default: begin
          out_data_d = ZERO_B;
          out_err_d  = 1'b0;
          out_wrap_d = 1'b0;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset drops any held result at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= ZERO_B;
      out_valid_q <= 1'b0;
      out_data_q  <= ZERO_B;
      out_err_q   <= 1'b0;
      out_wrap_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_wrap_q  <= out_wrap_d;
    end
  end

endmodule

// File: tb/tb_gray_codec_counter.sv
// Directed + randomized bench for gray_codec_counter (WIDTH=4/MAX=9 and WIDTH=6/MAX=63)
// against an arithmetic reference model.
module tb_gray_codec_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_iv = 1'b0, a_ir, a_load = 1'b0, a_ov, a_ordy = 1'b1, a_err, a_wrap;
  logic [1:0] a_mode = 2'b00;
  logic [3:0] a_din = 4'd0, a_dout;
  logic       b_iv = 1'b0, b_ir, b_load = 1'b0, b_ov, b_ordy = 1'b1, b_err, b_wrap;
  logic [1:0] b_mode = 2'b00;
  logic [5:0] b_din = 6'd0, b_dout;

  int checks = 0;
  int passed = 0;
  int m4 = 0;
  int m6 = 0;

  always #5 clk = ~clk;

  gray_codec_counter #(.WIDTH(4), .MAX(9)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .mode(a_mode), .load(a_load),
    .in_data(a_din), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_dout),
    .out_err(a_err), .out_wrap(a_wrap));

  gray_codec_counter #(.WIDTH(6), .MAX(63)) dut6 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .mode(b_mode), .load(b_load),
    .in_data(b_din), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_dout),
    .out_err(b_err), .out_wrap(b_wrap));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain arithmetic on integers, Gray decode by table search.
  task automatic model(input int w, input int mx, input int md, input int ld, input int d,
                       inout int cnt, output int o, output int e, output int wr);
    int b;
    o = 0; e = 0; wr = 0; b = -1;
    case (md)
      0: if (d > mx) e = 1; else o = d ^ (d >> 1);
      1: begin
        for (int v = 0; v < (1 << w); v++) if ((v ^ (v >> 1)) == d) b = v;
        if (b > mx) e = 1; else o = b;
      end
      default: begin
        if (ld != 0) begin
          if (d > mx) e = 1;
          else begin cnt = d; o = d ^ (d >> 1); end
        end else begin
          if (md == 2) begin wr = (cnt == mx) ? 1 : 0; cnt = (cnt + 1) % (mx + 1); end
          else begin wr = (cnt == 0) ? 1 : 0; cnt = (cnt + mx) % (mx + 1); end
          o = cnt ^ (cnt >> 1);
        end
      end
    endcase
  endtask

  // One transaction with out_ready=1; xd/xe/xw < 0 skip the constant check.
  task automatic send(input bit s, input int md, input int ld, input int d,
                      input int xd, input int xe, input int xw, input string tag, output int got);
    int eo, ee, ew;
    @(negedge clk);
    if (!s) begin
      a_iv = 1'b1; a_mode = md[1:0]; a_load = ld[0]; a_din = d[3:0];
      model(4, 9, md, ld, d, m4, eo, ee, ew);
    end else begin
      b_iv = 1'b1; b_mode = md[1:0]; b_load = ld[0]; b_din = d[5:0];
      model(6, 63, md, ld, d, m6, eo, ee, ew);
    end
    #1;
    chk({tag, "/in_ready"}, s ? b_ir : a_ir, 1);
    @(posedge clk);
    #1;
    a_iv = 1'b0; b_iv = 1'b0;
    chk({tag, "/valid"}, s ? b_ov : a_ov, 1);
    got = s ? int'(b_dout) : int'(a_dout);
    chk({tag, "/data"}, got, eo);
    chk({tag, "/err"}, s ? b_err : a_err, ee);
    chk({tag, "/wrap"}, s ? b_wrap : a_wrap, ew);
    if (xd >= 0) chk({tag, "/data_const"}, got, xd);
    if (xe >= 0) chk({tag, "/err_const"}, s ? b_err : a_err, xe);
    if (xw >= 0) chk({tag, "/wrap_const"}, s ? b_wrap : a_wrap, xw);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst/valid", a_ov, 0);
    chk("rst/data", a_dout, 0);
    chk("rst/err", a_err, 0);
    chk("rst/wrap", a_wrap, 0);
    chk("rst/ready", a_ir, 1);
    chk("rst/valid6", b_ov, 0);
    @(negedge clk);
    rst = 1'b0;
    m4 = 0; m6 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, prev;
    do_reset();

    // Conversions
    send(0, 0, 0, 7,  4, 0, 0, "b2g_7", g);
    send(0, 0, 1, 9, 13, 0, 0, "b2g_9_load_ignored", g);
    send(0, 0, 0, 10, 0, 1, 0, "b2g_10_err", g);
    send(0, 1, 0, 13, 9, 0, 0, "g2b_13", g);
    send(0, 1, 0, 15, 0, 1, 0, "g2b_15_err", g);

    // Count up with wrap
    send(0, 2, 1, 8, 12, 0, 0, "up_load8", g);
    send(0, 2, 0, 0, 13, 0, 0, "up_9", g);
    send(0, 2, 0, 0,  0, 0, 1, "up_wrap", g);
    send(0, 2, 0, 0,  1, 0, 0, "up_1", g);

    // Count down from reset, illegal load leaves cnt alone
    do_reset();
    send(0, 3, 0, 0, 13, 0, 1, "dn_wrap", g);
    send(0, 3, 0, 0, 12, 0, 0, "dn_8", g);
    send(0, 3, 1, 12, 0, 1, 0, "dn_badload", g);
    send(0, 3, 0, 0,  4, 0, 0, "dn_7", g);

    // Backpressure
    send(0, 2, 1, 2, 3, 0, 0, "bp_load2", g);
    @(negedge clk);
    a_ordy = 1'b0; a_iv = 1'b1; a_mode = 2'b10; a_load = 1'b0; a_din = 4'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp/in_ready_low", a_ir, 0);
      @(posedge clk);
      #1;
      chk("bp/valid_held", a_ov, 1);
      chk("bp/data_held", a_dout, 3);
      @(negedge clk);
    end
    a_ordy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int eo, ee, ew;
      model(4, 9, 2, 0, 0, m4, eo, ee, ew);
      #1;
      chk("bp/in_ready_high", a_ir, 1);
      @(posedge clk);
      #1;
      chk("bp/step_data", a_dout, eo);
      chk("bp/step_const", a_dout, (k == 0) ? 2 : 6);
      @(negedge clk);
    end
    a_iv = 1'b0;

    // Asynchronous reset while a result is held
    send(0, 2, 0, 0, 7, 0, 0, "mid_pre", g);
    a_ordy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid/valid_dropped", a_ov, 0);
    chk("mid/data_cleared", a_dout, 0);
    @(negedge clk);
    rst = 1'b0; a_ordy = 1'b1;
    m4 = 0; m6 = 0;
    send(0, 2, 0, 0, 1, 0, 0, "mid_first_up", g);

    // WIDTH=6 round trip sweep
    for (int v = 0; v < 64; v++) begin
      send(1, 0, 0, v, -1, 0, 0, "sw_b2g", g);
      send(1, 1, 0, g, v, 0, 0, "sw_g2b", r);
    end

    // WIDTH=6 count-up single-bit-change sweep through the wrap
    do_reset();
    prev = 0;
    for (int k = 0; k < 66; k++) begin
      send(1, 2, 0, 0, -1, 0, -1, "sw_up", g);
      chk("sw_up/one_bit", $countones(prev ^ g), 1);
      prev = g;
    end

    // Randomized traffic on WIDTH=4
    for (int k = 0; k < 300; k++) begin
      send(0, $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(15, 0),
           -1, -1, -1, "rand", g);
      if ($urandom_range(3, 0) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
